dqs_burst_sequencer: RTL

Parametrised DQS strobe sequencer for the LPDDR4 write path. It replaces per-cycle external mode selection with an internal FSM that accepts write-burst requests and autonomously emits preamble, toggle, and postamble words per byte lane. It also supports seamless back-to-back bursts and a write-levelling strobe mode. Its output feeds the per-lane DQS serialisers, one SER_W-bit SDR word per lane per i_clk.

---
 rtl/dqs_seq_pkg.sv | 13 +
 rtl/dqs_lane_out.sv | 26 ++
 rtl/dqs_burst_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/dqs_seq_pkg.sv
// dqs_seq_pkg: shared state encoding and widths for the DQS burst sequencer.
package dqs_seq_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    BURST     = 3'd2,
    POST      = 3'd3,
    WL_IDLE   = 3'd4,
    WL_STROBE = 3'd5
  } state_e;
  localparam int PRE_W       = 3;
  localparam int BURST_CNT_W = 16;
endpackage

// File: rtl/dqs_lane_out.sv
// dqs_lane_out: per-lane registered DQS word and output enable, gated by the lane mask.
module dqs_lane_out #(
  parameter int SER_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SER_W-1:0] word_i,
  input  logic             en_i,
  input  logic             mask_i,
  output logic [SER_W-1:0] word_o,
  output logic             oe_o
);
  logic [SER_W-1:0] word_q;
  logic             oe_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      word_q <= '0;
      oe_q   <= 1'b0;
    end else begin
      word_q <= word_i & {SER_W{mask_i}};
      oe_q   <= mask_i & en_i;
    end
  end
  assign word_o = word_q;
  assign oe_o   = oe_q;
endmodule

// File: rtl/dqs_burst_sequencer.sv
// dqs_burst_sequencer: DQS preamble/toggle/postamble sequencer with seamless bursts and write levelling.
// Define DQS_BURST_CNT_EN to add the o_burst_cnt completed-burst counter.
module dqs_burst_sequencer
  import dqs_seq_pkg::*;
#(
  parameter int SER_W     = 8,
  parameter int NUM_LANES = 2,
  parameter int LEN_W     = 6
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_valid,
  output logic                       o_wr_ready,
  input  logic [LEN_W-1:0]           i_wr_len,
  input  logic [2:0]                 i_pre_cyc,
  input  logic [2:0]                 i_post_cyc,
  input  logic [SER_W-1:0]           i_preamble,
  input  logic [SER_W-1:0]           i_postamble,
  input  logic [SER_W-1:0]           i_toggle_pat,
  input  logic                       i_wl_en,
  input  logic                       i_wl_strobe_req,
  input  logic [SER_W-1:0]           i_wl_strobe,
  input  logic [NUM_LANES-1:0]       i_lane_mask,
  output logic [NUM_LANES*SER_W-1:0] o_tx_dqs_sdr,
  output logic [NUM_LANES-1:0]       o_dqs_oe,
  output logic                       o_busy,
  output logic [2:0]                 o_state
`ifdef DQS_BURST_CNT_EN
  ,
  output logic [BURST_CNT_W-1:0]     o_burst_cnt
`endif
);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic [PRE_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [PRE_W-1:0] post_q, post_d;
  logic [SER_W-1:0] word_sel;
  logic             oe_en, last_burst, accept;
  assign last_burst = (state_q == BURST) && (len_cnt_q == '0);
  assign o_wr_ready = !i_rst && (((state_q == IDLE) && !i_wl_en) || last_burst);
  assign accept     = i_wr_valid && o_wr_ready;
  assign o_busy     = state_q != IDLE;
  assign o_state    = state_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      len_cnt_q <= '0;
      ph_cnt_q  <= '0;
      post_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_cnt_q <= len_cnt_d;
      ph_cnt_q  <= ph_cnt_d;
      post_q    <= post_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = i_wl_en ? WL_IDLE : accept ? ((i_pre_cyc != '0) ? PRE : BURST) : IDLE;
      PRE:       state_d = (ph_cnt_q == '0) ? BURST : PRE;
      BURST:     state_d = (!last_burst || accept) ? BURST : (post_q != '0) ? POST : IDLE;
      POST:      state_d = (ph_cnt_q == '0) ? IDLE : POST;
      WL_IDLE:   state_d = !i_wl_en ? IDLE : i_wl_strobe_req ? WL_STROBE : WL_IDLE;
      WL_STROBE: state_d = WL_IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // len_cnt holds the latched length through PRE and counts down to 0 on the last BURST cycle
  always_comb begin
    post_d    = accept ? i_post_cyc : post_q;
    len_cnt_d = accept ? i_wr_len
              : ((state_q == BURST) && (len_cnt_q != '0)) ? len_cnt_q - 1'b1 : len_cnt_q;
    ph_cnt_d  = (accept && (state_q == IDLE)) ? ((i_pre_cyc != '0) ? i_pre_cyc - 1'b1 : '0)
              : ((state_q == BURST) && (state_d == POST)) ? post_q - 1'b1
              : (((state_q == PRE) || (state_q == POST)) && (ph_cnt_q != '0)) ? ph_cnt_q - 1'b1
              : ph_cnt_q;
  end
  always_comb begin
    word_sel = (state_d == PRE)       ? i_preamble
             : (state_d == BURST)     ? i_toggle_pat
             : (state_d == POST)      ? i_postamble
             : (state_d == WL_STROBE) ? i_wl_strobe : '0;
    oe_en    = state_d != IDLE;
  end
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    dqs_lane_out #(.SER_W(SER_W)) u_lane (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .word_i (word_sel),
      .en_i   (oe_en),
      .mask_i (i_lane_mask[k]),
      .word_o (o_tx_dqs_sdr[k*SER_W +: SER_W]),
      .oe_o   (o_dqs_oe[k])
    );
  end
`ifdef DQS_BURST_CNT_EN
  logic [BURST_CNT_W-1:0] burst_cnt_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) burst_cnt_q <= '0;
    else if (last_burst) burst_cnt_q <= burst_cnt_q + 1'b1;
  end
  assign o_burst_cnt = burst_cnt_q;
`endif
endmodule
